fetch_unit: RTL and testbench

Instruction fetch stage of the single-cycle RV32I core. Holds the program counter, issues one instruction-memory read at a time over a req/gnt/rvalid handshake, and presents the fetched word to decode over a valid/ready handshake. It sits directly upstream of the next-PC select mux:
- `pc_plus4` drives the mux's fall-through input.
- The mux output returns here as `redirect_pc`.

---
 rtl/fetch_unit.sv | 147 ++++++++++++++
 tb/tb_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage with imem req/gnt/rvalid and decode valid/ready.
// Ports: clk, rst_n, redirect_*, imem_*, inst_*, pc_plus4, misalign_err; option FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst,
  output logic [DATA_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);
  localparam logic [31:0]           NOP  = 32'h0000_0013;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d, tgt;
  logic                  drop_q, drop_d;
  logic                  err_q, err_d;
  logic                  bad, redir, cap;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign tgt = redirect_pc;
  assign bad = redirect_valid & (|redirect_pc[1:0]);
`else
  logic unused_lo;
  assign unused_lo = ^redirect_pc[1:0];
  assign tgt = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign bad = 1'b0;
`endif

  assign redir = redirect_valid & ~bad;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    drop_d     = drop_q;
    err_d      = err_q;
    cap        = 1'b0;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redir) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (!err_q) begin
          state_d = REQ;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (redir) begin
          pc_d = tgt;
          if (imem_gnt) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end else if (imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir) begin
          pc_d = tgt;
          // Response arriving with the redirect belongs to the old pc.
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            cap     = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        inst_valid = ~redirect_valid;
        if (redir) begin
          pc_d    = tgt;
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + FOUR;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Misaligned target parks the stage until an aligned redirect.
    if (bad) begin
      state_d = IDLE;
      drop_d  = 1'b0;
      err_d   = 1'b1;
    end else if (redir) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      inst    <= NOP;
      inst_pc <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      if (cap) begin
        inst    <= imem_rdata;
        inst_pc <= pc_q;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign pc_plus4     = inst_pc + FOUR;
  assign misalign_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit with a zero-wait memory model.
// Memory returns addr + 0x93 one cycle after grant.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .DATA_WIDTH  (32),
    .RESET_VECTOR(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .pc_plus4      (pc_plus4),
    .misalign_err  (misalign_err)
  );

  assign imem_gnt = imem_req;

  always_ff @(posedge clk) begin
    imem_rvalid <= imem_req & imem_gnt;
    imem_rdata  <= imem_addr + 32'h93;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk(tag, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic [31:0] a);
    int n = 0;
    while (!imem_req && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    chk({tag, "_addr"}, imem_addr, a);
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    step();
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h13);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    rst_n = 1'b1;

    step();
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h0);
    step();
    chk("f0_wait_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("f0_valid", {31'd0, inst_valid}, 32'd1);
    chk("f0_inst", inst, 32'h93);
    chk("f0_pc", inst_pc, 32'h0);
    chk("f0_pc4", pc_plus4, 32'h4);
    step();
    chk("f1_valid", {31'd0, inst_valid}, 32'd0);
    chk("f1_req", {31'd0, imem_req}, 32'd1);
    chk("f1_addr", imem_addr, 32'h4);

    inst_ready = 1'b0;
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      chk("stall_hold", {31'd0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h97);
      chk("stall_pc", inst_pc, 32'h4);
      chk("stall_noreq", {31'd0, imem_req}, 32'd0);
      step();
    end
    inst_ready = 1'b1;
    step();
    chk("stall_next_req", {31'd0, imem_req}, 32'd1);
    chk("stall_next_addr", imem_addr, 32'h8);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    chk("rg_wait_req", {31'd0, imem_req}, 32'd0);
    wait_req("rg", 32'h100);
    wait_valid("rg_valid");
    chk("rg_inst", inst, 32'h193);
    chk("rg_pc", inst_pc, 32'h100);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    #1;
    chk("rh_squash", {31'd0, inst_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("rh_req", {31'd0, imem_req}, 32'd1);
    chk("rh_addr", imem_addr, 32'h40);
    wait_valid("rh_valid");
    chk("rh_inst", inst, 32'hD3);
    chk("rh_pc", inst_pc, 32'h40);

    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_valid");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4, 32'h0);
    chk("wrap_inst", inst, 32'h8F);
    step();
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk("wrap_next", imem_addr, 32'h0);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_noreq", {31'd0, imem_req}, 32'd0);
    step();
    step();
    chk("mis_err_hold", {31'd0, misalign_err}, 32'd1);
    chk("mis_noreq_hold", {31'd0, imem_req}, 32'd0);
    chk("mis_novalid", {31'd0, inst_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("mis_clr", {31'd0, misalign_err}, 32'd0);
    chk("mis_req", {31'd0, imem_req}, 32'd1);
    chk("mis_addr", imem_addr, 32'h200);
`else
    chk("mask_err", {31'd0, misalign_err}, 32'd0);
    wait_req("mask", 32'h100);
    wait_valid("mask_valid");
    chk("mask_pc", inst_pc, 32'h100);
`endif

    begin
      int n = 0;
      while (!imem_req && n < 20) begin
        step();
        n++;
      end
      chk("mt_req", {31'd0, imem_req}, 32'd1);
    end
    step();
    rst_n = 1'b0;
    #1;
    chk("mt_req0", {31'd0, imem_req}, 32'd0);
    chk("mt_valid0", {31'd0, inst_valid}, 32'd0);
    chk("mt_inst", inst, 32'h13);
    chk("mt_pc", inst_pc, 32'h0);
    chk("mt_err", {31'd0, misalign_err}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("mt_resume_req", {31'd0, imem_req}, 32'd1);
    chk("mt_resume_addr", imem_addr, 32'h0);
    chk("mt_resume_valid", {31'd0, inst_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
